// File: rtl/tcdm_stream_pkg.sv
// Shared types for the TCDM strided read-stream master.
package tcdm_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam logic [3:0] AMO_NONE = 4'h0;

endpackage

// File: rtl/tcdm_stream_rsp_fifo.sv
// Power-of-2 circular response buffer with registered head and no fall-through.
module tcdm_stream_rsp_fifo #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [DataWidth-1:0]   data_i,
    input  logic                   pop_i,
    output logic [DataWidth-1:0]   data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot a full push needs.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/tcdm_stream_reader.sv
// Strided TCDM read master: issues len credit-limited reads and streams
// the in-order responses out through a small FIFO.
module tcdm_stream_reader
    import tcdm_stream_pkg::*;
#(
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned TCDMAddrWidth   = 17,
    parameter int unsigned LenWidth        = 16,
    parameter int unsigned FifoDepth       = 4,
    parameter int unsigned CoreId          = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [TCDMAddrWidth-1:0]     base_addr_i,
    input  logic [TCDMAddrWidth-1:0]     stride_i,
    input  logic [LenWidth-1:0]          len_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         tcdm_req_write_o,
    output logic [TCDMAddrWidth-1:0]     tcdm_req_addr_o,
    output logic [3:0]                   tcdm_req_amo_o,
    output logic [NarrowDataWidth-1:0]   tcdm_req_data_o,
    output logic [NarrowDataWidth/8-1:0] tcdm_req_strb_o,
    output logic [4:0]                   tcdm_req_user_core_id_o,
    output logic                         tcdm_req_user_is_core_o,
    output logic                         tcdm_req_q_valid_o,
    input  logic                         tcdm_rsp_q_ready_i,
    input  logic                         tcdm_rsp_p_valid_i,
    input  logic [NarrowDataWidth-1:0]   tcdm_rsp_data_i,
    output logic [NarrowDataWidth-1:0]   data_o,
    output logic                         valid_o,
    input  logic                         ready_i
);

    localparam int unsigned CntW = $clog2(FifoDepth) + 1;

    state_e                   state_q, state_d;
    logic [TCDMAddrWidth-1:0] addr_q, addr_d;
    logic [TCDMAddrWidth-1:0] stride_q, stride_d;
    logic [LenWidth-1:0]      len_q, len_d;
    logic [LenWidth-1:0]      issued_q, issued_d;
    logic [CntW-1:0]          outst_q, outst_d;
    logic                     done_q, done_d;
    logic [1:0]               win_q;

    logic [CntW-1:0] fifo_cnt, credit;
    logic            fifo_full, fifo_empty;
    logic            gnt, rsp_ok, pop;

    assign tcdm_req_write_o        = 1'b0;
    assign tcdm_req_amo_o          = AMO_NONE;
    assign tcdm_req_data_o         = '0;
    assign tcdm_req_strb_o         = '1;
    assign tcdm_req_user_core_id_o = 5'(CoreId);
    assign tcdm_req_user_is_core_o = 1'b0;
    assign tcdm_req_addr_o         = addr_q;

    // Credit only shrinks on a grant, so a raised request is never withdrawn.
    assign credit             = CntW'(FifoDepth) - outst_q - fifo_cnt;
    assign tcdm_req_q_valid_o = (state_q == RUN) && (credit != '0);
    assign gnt                = tcdm_req_q_valid_o & tcdm_rsp_q_ready_i;
    assign rsp_ok             = tcdm_rsp_p_valid_i & (outst_q != '0);

    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign valid_o = ~fifo_empty;
    assign pop     = valid_o & ready_i;

    tcdm_stream_rsp_fifo #(
        .DataWidth (NarrowDataWidth),
        .Depth     (FifoDepth)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rsp_ok),
        .data_i  (tcdm_rsp_data_i),
        .pop_i   (pop),
        .data_o  (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        len_d    = len_q;
        issued_d = issued_q;
        done_d   = 1'b0;
        outst_d  = outst_q + CntW'(gnt) - CntW'(rsp_ok);
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d  = RUN;
                        addr_d   = base_addr_i;
                        stride_d = stride_i;
                        len_d    = len_i;
                        issued_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (gnt) begin
                    addr_d   = addr_q + stride_q;
                    issued_d = issued_q + LenWidth'(1);
                    if (issued_q == len_q - LenWidth'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outst_q == '0 && fifo_empty) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            issued_q <= '0;
            outst_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            outst_q  <= outst_d;
            done_q   <= done_d;
        end
    end

    // Responses to reads in flight at reset are expected for a few cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            win_q <= 2'd3;
        end else begin
            if (win_q != 2'd0) win_q <= win_q - 2'd1;
            if (win_q == 2'd0) begin
                assert (!(tcdm_rsp_p_valid_i && outst_q == '0))
                else $error("response with no outstanding read dropped");
            end
        end
    end

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_tcdm_stream_reader.sv
// Directed and randomized checks of tcdm_stream_reader against an
// arithmetic address/data model and a 1-cycle-latency TCDM responder.
module tb_tcdm_stream_reader;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [16:0] base_addr_i;
    logic [16:0] stride_i;
    logic [15:0] len_i;
    logic        busy_o;
    logic        done_o;
    logic        tcdm_req_write_o;
    logic [16:0] tcdm_req_addr_o;
    logic [3:0]  tcdm_req_amo_o;
    logic [63:0] tcdm_req_data_o;
    logic [7:0]  tcdm_req_strb_o;
    logic [4:0]  tcdm_req_user_core_id_o;
    logic        tcdm_req_user_is_core_o;
    logic        tcdm_req_q_valid_o;
    logic        tcdm_rsp_q_ready_i;
    logic        tcdm_rsp_p_valid_i;
    logic [63:0] tcdm_rsp_data_i;
    logic [63:0] data_o;
    logic        valid_o;
    logic        ready_i;

    tcdm_stream_reader dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_ni),
        .start_i                 (start_i),
        .base_addr_i             (base_addr_i),
        .stride_i                (stride_i),
        .len_i                   (len_i),
        .busy_o                  (busy_o),
        .done_o                  (done_o),
        .tcdm_req_write_o        (tcdm_req_write_o),
        .tcdm_req_addr_o         (tcdm_req_addr_o),
        .tcdm_req_amo_o          (tcdm_req_amo_o),
        .tcdm_req_data_o         (tcdm_req_data_o),
        .tcdm_req_strb_o         (tcdm_req_strb_o),
        .tcdm_req_user_core_id_o (tcdm_req_user_core_id_o),
        .tcdm_req_user_is_core_o (tcdm_req_user_is_core_o),
        .tcdm_req_q_valid_o      (tcdm_req_q_valid_o),
        .tcdm_rsp_q_ready_i      (tcdm_rsp_q_ready_i),
        .tcdm_rsp_p_valid_i      (tcdm_rsp_p_valid_i),
        .tcdm_rsp_data_i         (tcdm_rsp_data_i),
        .data_o                  (data_o),
        .valid_o                 (valid_o),
        .ready_i                 (ready_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int gidx, pidx, ndone;
    int gnt_pct, rdy_pct;
    logic [16:0] cur_base, cur_stride;
    logic qv_seen;

    function automatic logic [63:0] mem(logic [16:0] a);
        logic [31:0] lo, hi;
        lo = 32'hC0DE_0000 ^ 32'(a);
        hi = ~(32'(a) * 32'd2654435761);
        return {hi, lo};
    endfunction

    function automatic logic [16:0] exp_addr(int i);
        logic [31:0] t;
        t = 32'(cur_base) + 32'(i) * 32'(cur_stride);
        return t[16:0];
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic        gnt, pop, qv;
        logic [16:0] a;
        logic [63:0] d;
        tcdm_rsp_q_ready_i = ($urandom_range(99) < 32'(gnt_pct));
        ready_i            = ($urandom_range(99) < 32'(rdy_pct));
        #1;
        qv  = tcdm_req_q_valid_o & rst_ni;
        gnt = tcdm_req_q_valid_o & tcdm_rsp_q_ready_i & rst_ni;
        a   = tcdm_req_addr_o;
        pop = valid_o & ready_i & rst_ni;
        d   = data_o;
        if (tcdm_req_q_valid_o) qv_seen = 1'b1;
        @(posedge clk);
        #1;
        tcdm_rsp_p_valid_i = 1'b0;
        if (gnt) begin
            chk("grant_addr", 64'(a), 64'(exp_addr(gidx)));
            gidx++;
            tcdm_rsp_p_valid_i = 1'b1;
            tcdm_rsp_data_i    = mem(a);
        end
        if (pop) begin
            chk("stream_data", d, mem(exp_addr(pidx)));
            pidx++;
        end
        if (qv && !gnt && rst_ni) begin
            chk("req_held", 64'(tcdm_req_q_valid_o), 64'd1);
            chk("addr_stable", 64'(tcdm_req_addr_o), 64'(a));
        end
        if (gidx - pidx > 4) chk("inflight_cap", 64'(gidx - pidx), 64'd4);
        if (done_o) ndone++;
    endtask

    task automatic start_cmd(logic [16:0] b, logic [16:0] s, logic [15:0] l);
        cur_base    = b;
        cur_stride  = s;
        gidx        = 0;
        pidx        = 0;
        ndone       = 0;
        qv_seen     = 1'b0;
        base_addr_i = b;
        stride_i    = s;
        len_i       = l;
        start_i     = 1'b1;
        cyc();
        start_i     = 1'b0;
        base_addr_i = $urandom();
        len_i       = 16'($urandom());
    endtask

    task automatic finish_cmd(int l);
        int n;
        n = 0;
        while (ndone == 0 && n < 600) begin
            cyc();
            n++;
        end
        chk("done_in_time", 64'(ndone != 0), 64'd1);
        cyc();
        cyc();
        chk("done_once", 64'(ndone), 64'd1);
        chk("grants", 64'(gidx), 64'(l));
        chk("pops", 64'(pidx), 64'(l));
        chk("busy_after", 64'(busy_o), 64'd0);
        chk("done_low", 64'(done_o), 64'd0);
    endtask

    initial begin
        rst_ni             = 1'b0;
        start_i            = 1'b0;
        base_addr_i        = '0;
        stride_i           = '0;
        len_i              = '0;
        tcdm_rsp_q_ready_i = 1'b0;
        tcdm_rsp_p_valid_i = 1'b0;
        tcdm_rsp_data_i    = '0;
        ready_i            = 1'b0;
        gnt_pct            = 100;
        rdy_pct            = 100;
        gidx = 0; pidx = 0; ndone = 0;
        cur_base = '0; cur_stride = '0; qv_seen = 1'b0;
        cyc();
        cyc();
        chk("rst_qvalid", 64'(tcdm_req_q_valid_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_addr", 64'(tcdm_req_addr_o), 64'd0);
        chk("const_strb", 64'(tcdm_req_strb_o), 64'hFF);
        chk("const_write", 64'(tcdm_req_write_o), 64'd0);
        rst_ni = 1'b1;
        cyc();

        // Basic stream, with start-to-first-valid latency.
        gnt_pct = 100; rdy_pct = 100;
        start_cmd(17'h100, 17'd8, 16'd4);
        chk("busy_run", 64'(busy_o), 64'd1);
        cyc();
        chk("lat_not_yet", 64'(valid_o), 64'd0);
        cyc();
        chk("lat_first_valid", 64'(valid_o), 64'd1);
        finish_cmd(4);

        // Consumer stalled: issue stops at FIFO depth.
        rdy_pct = 0;
        start_cmd(17'h200, 17'd4, 16'd8);
        repeat (20) cyc();
        chk("stall_grants", 64'(gidx), 64'd4);
        chk("stall_qvalid", 64'(tcdm_req_q_valid_o), 64'd0);
        rdy_pct = 100;
        finish_cmd(8);

        // Bank contention from another port.
        gnt_pct = 35; rdy_pct = 70;
        start_cmd(17'h040, 17'h18, 16'd16);
        finish_cmd(16);

        // Address wrap.
        gnt_pct = 100; rdy_pct = 100;
        start_cmd(17'h1FFF8, 17'h10, 16'd2);
        chk("wrap_model", 64'(exp_addr(1)), 64'h8);
        finish_cmd(2);

        // Zero-length command.
        start_cmd(17'h300, 17'd8, 16'd0);
        chk("len0_done", 64'(done_o), 64'd1);
        chk("len0_busy", 64'(busy_o), 64'd0);
        repeat (5) cyc();
        chk("len0_no_req", 64'(qv_seen), 64'd0);
        chk("len0_done_once", 64'(ndone), 64'd1);

        // Reset with reads in flight, stray late response, then a fresh run.
        gnt_pct = 100; rdy_pct = 0;
        start_cmd(17'h500, 17'd8, 16'd8);
        cyc();
        cyc();
        chk("pre_rst_grants", 64'(gidx), 64'd2);
        rst_ni = 1'b0;
        cyc();
        chk("mid_rst_qvalid", 64'(tcdm_req_q_valid_o), 64'd0);
        chk("mid_rst_valid", 64'(valid_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_done", 64'(done_o), 64'd0);
        chk("mid_rst_addr", 64'(tcdm_req_addr_o), 64'd0);
        rst_ni = 1'b1;
        tcdm_rsp_p_valid_i = 1'b1;
        tcdm_rsp_data_i    = 64'hDEAD_BEEF_0BAD_F00D;
        cyc();
        chk("stray_dropped", 64'(valid_o), 64'd0);
        cyc();
        chk("stray_still_empty", 64'(valid_o), 64'd0);
        rdy_pct = 100;
        start_cmd(17'h600, 17'h20, 16'd5);
        finish_cmd(5);

        // Random commands under random grant and consumer pressure.
        for (int k = 0; k < 4; k++) begin
            gnt_pct = $urandom_range(90, 20);
            rdy_pct = $urandom_range(90, 20);
            start_cmd(17'($urandom()), 17'($urandom()),
                      16'($urandom_range(12, 1)));
            finish_cmd(int'(len_i == len_i) * 0 + int'(cur_len_hack()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    logic [15:0] last_len;
    always @(posedge clk) if (start_i && !busy_o) last_len <= len_i;

    function automatic int cur_len_hack();
        return int'(last_len);
    endfunction

endmodule
